// File: rtl/sub_serial_ctrl.sv
// Bit/digit-serial subtract sequencer: one DIGIT-bit subtract slice is reused
// over a WIDTH-bit operand pair, least significant slice first, with the
// borrow carried between slices. Valid/ready handshakes on input and output.
module sub_serial_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sub,
  output logic             Borrow,
  output logic             busy
);

  localparam int unsigned N    = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW   = DIGIT + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  // Reject slice widths that do not tile the operand exactly.
  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("sub_serial_ctrl: DIGIT must be nonzero and divide WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             brw_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-1:0] sub_q;
  logic             borrow_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [DW-1:0]    diff;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bout;
  logic [WIDTH-1:0] res_next;
  logic             accept;

  // Slice subtractor, result shift, and input handshake.
  always_comb begin
    diff       = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - DW'(brw_q);
    slice_bout = diff[DIGIT];
    slice_d    = diff[DIGIT-1:0];
    // Slices enter at the top so the first one ends up least significant.
    res_next   = (res_q >> DIGIT) | (WIDTH'(slice_d) << (WIDTH - DIGIT));
    in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    accept     = in_valid && in_ready;
  end

  // Sequencer FSM with registered outputs; Sub/Borrow only load on RUN->DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      brw_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sub_q       <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            a_q         <= A;
            b_q         <= B;
            cnt_q       <= '0;
            brw_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StRun;
          end else if (state_q == StDone && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          res_q <= res_next;
          brw_q <= slice_bout;
          if (cnt_q == LastCnt) begin
            sub_q       <= res_next;
            borrow_q    <= slice_bout;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign Sub       = sub_q;
  assign Borrow    = borrow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sub_serial_ctrl.sv
// Directed bench for sub_serial_ctrl: a DIGIT=1 instance for protocol,
// latency, backpressure and reset cases, and a DIGIT=4 instance for a sweep.
module tb_sub_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, borrow, busy;
  logic [15:0] sub;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, borrow4, busy4;
  logic [15:0] sub4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sub_serial_ctrl #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready), .Sub(sub), .Borrow(borrow), .busy(busy)
  );

  sub_serial_ctrl #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .A(a4), .B(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .Sub(sub4), .Borrow(borrow4),
    .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One DIGIT=1 operation; ends with the DUT holding the result in DONE.
  task automatic op1(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                     input logic [15:0] es, input logic eb,
                     input logic [15:0] ps, input logic pb, input bit from_done);
    int lat;
    int bcnt;
    bit held;
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib;
    if (from_done) out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    lat = 0; bcnt = 0; held = 1'b1;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      if (sub !== ps || borrow !== pb) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 16);
    chk({tag, "_busy_cycles"}, bcnt, 16);
    chk({tag, "_hold_prev"}, {31'd0, held}, 1);
    chk({tag, "_sub"}, {16'd0, sub}, {16'd0, es});
    chk({tag, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
  endtask

  task automatic rel1(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_rel_busy"}, {31'd0, busy}, 0);
  endtask

  task automatic op4(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                     input logic [15:0] es, input logic eb);
    int lat;
    @(negedge clk);
    in_valid4 = 1'b1; a4 = ia; b4 = ib;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_sub"}, {16'd0, sub4}, {16'd0, es});
    chk({tag, "_borrow"}, {31'd0, borrow4}, {31'd0, eb});
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_sub", {16'd0, sub}, 0);
    chk("rst_borrow", {31'd0, borrow}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;

    // Basic op
    op1("t1", 16'h1234, 16'h0034, 16'h1200, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Backpressure in DONE: in_valid toggling must not capture
    a = 16'hFFFF; b = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      #1;
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_sub", {16'd0, sub}, 32'h1200);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_busy", {31'd0, busy}, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_rel_valid", {31'd0, out_valid}, 0);
    chk("bp_rel_busy", {31'd0, busy}, 0);
    chk("bp_rel_in_ready", {31'd0, in_ready}, 1);

    // Borrow / wrap cases
    op1("t2a", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 16'h1200, 1'b0, 1'b0);
    rel1("t2a");
    op1("t2b", 16'h8000, 16'h8000, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    rel1("t2b");
    op1("t2c", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Back-to-back release and accept from DONE
    op1("t4", 16'h0100, 16'h0001, 16'h00FF, 1'b0, 16'h8000, 1'b1, 1'b1);
    rel1("t4");

    // Reset mid-operation at counter 7
    op1("t5pre", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 16'h00FF, 1'b0, 1'b0);
    rel1("t5pre");
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1111; b = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("t5_busy_before", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", {31'd0, out_valid}, 0);
    chk("t5_sub", {16'd0, sub}, 0);
    chk("t5_borrow", {31'd0, borrow}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_in_ready", {31'd0, in_ready}, 1);
    op1("t5post", 16'h0005, 16'h0003, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b0);
    rel1("t5post");

    // DIGIT=4 instance
    op4("d4a", 16'hABCD, 16'h1234, 16'h9999, 1'b0);
    op4("d4b", 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
    op4("d4c", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      op4("d4rnd", ra, rb, 16'(ra - rb), ra < rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
